serializer_arbiter: RTL

//  Shares one SPI serializer between NREQ requesters. Picks a requester round-robin and presents
//  its word to the serializer. Sequences the serializer with a reset pulse, then a gap, then a
//  one-cycle trigger. Waits for the serializer's done, then acks the requester.

---
 rtl/serializer_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 27 ++
 rtl/serializer_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared definitions for the serializer arbiter: FSM encodings, default SPI-path timing, clog2 helper.
package serializer_pkg;

    localparam int unsigned DEF_RST_CYC = 1;
    localparam int unsigned DEF_GAP_CYC = 1;

    localparam int unsigned ST_W = 6;
    localparam logic [ST_W-1:0] ST_IDLE = 6'b000001;
    localparam logic [ST_W-1:0] ST_RST  = 6'b000010;
    localparam logic [ST_W-1:0] ST_GAP  = 6'b000100;
    localparam logic [ST_W-1:0] ST_TRIG = 6'b001000;
    localparam logic [ST_W-1:0] ST_WAIT = 6'b010000;
    localparam logic [ST_W-1:0] ST_ACK  = 6'b100000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = ST_IDLE,
        S_RST  = ST_RST,
        S_GAP  = ST_GAP,
        S_TRIG = ST_TRIG,
        S_WAIT = ST_WAIT,
        S_ACK  = ST_ACK
    } state_e;

    // Ceiling log2, never less than 1 so it can size a vector directly.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin search: first set request after ptr, wrapping around; purely combinational.
module rr_arbiter
    import serializer_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [clog2(NREQ)-1:0]  ptr,
    output logic [clog2(NREQ)-1:0]  grant_c,
    output logic                    valid_c
);

    localparam int unsigned IW = clog2(NREQ);

    // Scan ptr+1 .. ptr+NREQ (mod NREQ); ptr itself is checked last.
    always_comb begin
        grant_c = '0;
        valid_c = 1'b0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            if (!valid_c && req[IW'((32'(ptr) + i) % NREQ)]) begin
                valid_c = 1'b1;
                grant_c = IW'((32'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/serializer_arbiter.sv
// Shares one SPI serializer between NREQ requesters: round-robin grant, reset/gap/trigger
// sequencing, wait for done, one-cycle ack. Define SER_ARB_TIMEOUT_EN to add a WAIT watchdog
// that forces ACK with err after TIMEOUT cycles.
module serializer_arbiter
    import serializer_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 32,
    parameter int unsigned RST_CYC = DEF_RST_CYC,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic                    ser_done,
    output logic [DW-1:0]           ser_data,
    output logic                    ser_reset,
    output logic                    ser_trigger,
    output logic [NREQ-1:0]         ack,
    output logic [clog2(NREQ)-1:0]  grant_id,
    output logic                    busy,
    output logic                    err
);

    localparam int unsigned IW      = clog2(NREQ);
    localparam int unsigned CNT_MAX = (RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC;
    localparam int unsigned CW      = clog2(CNT_MAX + 1);

    // Elaboration-time parameter sanity checks.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("serializer_arbiter: NREQ must be 2..8");
    end
    if (RST_CYC < 1 || GAP_CYC < 1 || TIMEOUT < 1) begin : g_bad_timing
        $error("serializer_arbiter: RST_CYC, GAP_CYC and TIMEOUT must be >= 1");
    end

    state_e             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [IW-1:0]      ptr, ptr_nxt;
    logic [IW-1:0]      arb_grant_c;
    logic               arb_valid_c;
    logic [IW-1:0]      grant_id_nxt;
    logic [DW-1:0]      ser_data_nxt;
    logic               ser_reset_nxt, ser_trigger_nxt, busy_nxt, err_nxt;
    logic [NREQ-1:0]    ack_nxt;

`ifdef SER_ARB_TIMEOUT_EN
    localparam int unsigned WW = clog2(TIMEOUT + 1);
    logic [WW-1:0]      wd, wd_nxt;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req),
        .ptr     (ptr),
        .grant_c (arb_grant_c),
        .valid_c (arb_valid_c)
    );

    // Next-state and next-output decode; outputs are registered from the next state.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ptr_nxt      = ptr;
        grant_id_nxt = grant_id;
        ser_data_nxt = ser_data;
        err_nxt      = 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
        wd_nxt       = '0;
`endif
        case (state)
            S_IDLE: begin
                if (arb_valid_c) begin
                    state_nxt    = S_RST;
                    cnt_nxt      = '0;
                    grant_id_nxt = arb_grant_c;
                    ser_data_nxt = req_data[32'(arb_grant_c) * DW +: DW];
                end
            end
            S_RST: begin
                if (cnt == CW'(RST_CYC - 1)) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt == CW'(GAP_CYC - 1)) begin
                    state_nxt = S_TRIG;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_TRIG: state_nxt = S_WAIT;
            S_WAIT: begin
                if (ser_done) begin
                    state_nxt = S_ACK;
                end
`ifdef SER_ARB_TIMEOUT_EN
                else if (wd == WW'(TIMEOUT - 1)) begin
                    state_nxt = S_ACK;
                    err_nxt   = 1'b1;
                end else begin
                    wd_nxt = wd + WW'(1);
                end
`endif
            end
            S_ACK: begin
                state_nxt = S_IDLE;
                ptr_nxt   = grant_id;
            end
            default: state_nxt = S_IDLE;
        endcase

        ser_reset_nxt   = (state_nxt == S_RST);
        ser_trigger_nxt = (state_nxt == S_TRIG);
        busy_nxt        = (state_nxt != S_IDLE);
        ack_nxt         = (state_nxt == S_ACK) ? (NREQ'(1) << grant_id_nxt) : '0;
    end

    // State, counters, grant/data latch and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ptr         <= IW'(NREQ - 1);
            grant_id    <= '0;
            ser_data    <= '0;
            ser_reset   <= 1'b0;
            ser_trigger <= 1'b0;
            ack         <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ptr         <= ptr_nxt;
            grant_id    <= grant_id_nxt;
            ser_data    <= ser_data_nxt;
            ser_reset   <= ser_reset_nxt;
            ser_trigger <= ser_trigger_nxt;
            ack         <= ack_nxt;
            busy        <= busy_nxt;
            err         <= err_nxt;
        end
    end

`ifdef SER_ARB_TIMEOUT_EN
    // WAIT watchdog counter; cleared whenever the FSM is not waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else begin
            wd <= wd_nxt;
        end
    end
`endif

endmodule
